led_pio_sequencer: RTL and testbench

//  Hardware LED pattern sequencer in front of the 2-bit LED PIO. The CPU configures it through an

---
 rtl/led_pio_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_led_pio_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pio_sequencer.sv
// LED pattern sequencer: Avalon-MM register slave plus a write-only master that replays a step table
// into the led_pio data register. Define LED_SEQ_IRQ_EN to add CTRL[2] (ie) and the done interrupt.
module led_pio_sequencer #(
    parameter int LED_W     = 2,
    parameter int NUM_STEPS = 4,
    parameter int PERIOD_W  = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);
    localparam logic [3:0] NUM_STEPS_L = 4'(NUM_STEPS);
    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_PERIOD = 4'd1;
    localparam logic [3:0] A_STATUS = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                run_q, run_d;
    logic                oneshot_q, oneshot_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                done_q, done_d;
    logic [LED_W-1:0]    step_tbl_q [NUM_STEPS];
    logic [LED_W-1:0]    step_tbl_d [NUM_STEPS];
    logic                m_cs_q, m_cs_d;
    logic                m_wr_n_q, m_wr_n_d;
    logic [LED_W-1:0]    m_wdata_q, m_wdata_d;
`ifdef LED_SEQ_IRQ_EN
    logic                ie_q, ie_d;
    logic                irq_q, irq_d;
`endif

    logic                wr_s;
    logic                start_s;
    logic                step_hit_s;
    logic [STEP_W-1:0]   step_idx_s;
    logic [STEP_W-1:0]   step_next_s;
    logic                unused_wdata_s;

    assign wr_s        = s_chipselect & ~s_write_n;
    // Only a genuine run 0->1 edge starts a sequence; rewriting run=1 never restarts it.
    assign start_s     = wr_s && (s_address == A_CTRL) && s_writedata[0] && !run_q;
    assign step_hit_s  = s_address[3] && ({1'b0, s_address[2:0]} < NUM_STEPS_L);
    assign step_idx_s  = s_address[STEP_W-1:0];
    assign step_next_s = step_q + STEP_W'(1'b1);
    assign unused_wdata_s = ^s_writedata;

    assign m_address    = 2'b00;
    assign m_chipselect = m_cs_q;
    assign m_write_n    = m_wr_n_q;
    assign m_writedata  = 32'(m_wdata_q);
`ifdef LED_SEQ_IRQ_EN
    assign irq          = irq_q;
`endif

    // Next-state: register-file writes first, then sequencing (so a done set beats a STATUS clear).
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        oneshot_d  = oneshot_q;
        period_d   = period_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        done_d     = done_q;
        step_tbl_d = step_tbl_q;
        m_cs_d     = m_cs_q;
        m_wr_n_d   = m_wr_n_q;
        m_wdata_d  = m_wdata_q;
`ifdef LED_SEQ_IRQ_EN
        ie_d       = ie_q;
`endif
        if (wr_s) begin
            case (s_address)
                A_CTRL: begin
                    run_d     = s_writedata[0];
                    oneshot_d = s_writedata[1];
`ifdef LED_SEQ_IRQ_EN
                    ie_d      = s_writedata[2];
`endif
                end
                A_PERIOD: period_d = s_writedata[PERIOD_W-1:0];
                A_STATUS: done_d   = 1'b0;
                default: begin
                    if (step_hit_s) begin
                        step_tbl_d[step_idx_s] = s_writedata[LED_W-1:0];
                    end else begin
                        step_tbl_d = step_tbl_q;
                    end
                end
            endcase
        end else begin
            done_d = done_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d   = ST_WRITE;
                    step_d    = {STEP_W{1'b0}};
                    m_cs_d    = 1'b1;
                    m_wr_n_d  = 1'b0;
                    m_wdata_d = step_tbl_q[0];
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // A stop request never aborts a transfer; it is honoured once the write is accepted.
                if (!m_waitrequest) begin
                    m_cs_d   = 1'b0;
                    m_wr_n_d = 1'b1;
                    if (run_q) begin
                        state_d = ST_WAIT;
                        cnt_d   = period_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WAIT: begin
                if (!run_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == {PERIOD_W{1'b0}}) begin
                    if (oneshot_q && (step_q == STEP_LAST)) begin
                        done_d  = 1'b1;
                        run_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        step_d    = step_next_s;
                        state_d   = ST_WRITE;
                        m_cs_d    = 1'b1;
                        m_wr_n_d  = 1'b0;
                        m_wdata_d = step_tbl_q[step_next_s];
                    end
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1'b1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                m_cs_d   = 1'b0;
                m_wr_n_d = 1'b1;
            end
        endcase
`ifdef LED_SEQ_IRQ_EN
        irq_d = done_d & ie_d;
`endif
    end

    // State and registered outputs; async reset drops the master request immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            oneshot_q  <= 1'b0;
            period_q   <= {PERIOD_W{1'b0}};
            cnt_q      <= {PERIOD_W{1'b0}};
            step_q     <= {STEP_W{1'b0}};
            done_q     <= 1'b0;
            step_tbl_q <= '{default: '0};
            m_cs_q     <= 1'b0;
            m_wr_n_q   <= 1'b1;
            m_wdata_q  <= {LED_W{1'b0}};
`ifdef LED_SEQ_IRQ_EN
            ie_q       <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            oneshot_q  <= oneshot_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            done_q     <= done_d;
            step_tbl_q <= step_tbl_d;
            m_cs_q     <= m_cs_d;
            m_wr_n_q   <= m_wr_n_d;
            m_wdata_q  <= m_wdata_d;
`ifdef LED_SEQ_IRQ_EN
            ie_q       <= ie_d;
            irq_q      <= irq_d;
`endif
        end
    end

    // Slave read mux, zero-filled.
    always_comb begin
        s_readdata = 32'd0;
        case (s_address)
            A_CTRL: begin
                s_readdata[0] = run_q;
                s_readdata[1] = oneshot_q;
`ifdef LED_SEQ_IRQ_EN
                s_readdata[2] = ie_q;
`endif
            end
            A_PERIOD: s_readdata[PERIOD_W-1:0] = period_q;
            A_STATUS: begin
                s_readdata[STEP_W-1:0] = step_q;
                s_readdata[8]          = (state_q != ST_IDLE);
                s_readdata[9]          = done_q;
            end
            default: begin
                if (step_hit_s) begin
                    s_readdata[LED_W-1:0] = step_tbl_q[step_idx_s];
                end else begin
                    s_readdata = 32'd0;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_led_pio_sequencer.sv
// Bench for led_pio_sequencer: behavioural model plus per-cycle compare, directed scenarios and random runs.
module tb_led_pio_sequencer;
    localparam int LED_W     = 2;
    localparam int NUM_STEPS = 4;
    localparam int PERIOD_W  = 24;

    logic        clk;
    logic        reset_n;
    logic [3:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
`ifdef LED_SEQ_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit wr_rand_en = 1'b0;
    int          acc_cyc[$];
    logic [31:0] acc_dat[$];

    // Model state: "busy" = sequence active, "issuing" = a write is being offered,
    // "gap" = idle cycles still owed before the next write.
    bit          m_busy = 1'b0;
    bit          m_issuing = 1'b0;
    int          m_gap = 0;
    int          m_step = 0;
    bit          m_run = 1'b0;
    bit          m_oneshot = 1'b0;
    bit          m_ie = 1'b0;
    bit          m_done = 1'b0;
    int          m_period = 0;
    logic [LED_W-1:0] m_tbl [NUM_STEPS] = '{default: '0};
    bit          exp_cs = 1'b0;
    logic [31:0] exp_wdata = 32'd0;
    bit          exp_irq = 1'b0;

    led_pio_sequencer #(.LED_W(LED_W), .NUM_STEPS(NUM_STEPS), .PERIOD_W(PERIOD_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_waitrequest(m_waitrequest)
`ifdef LED_SEQ_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (a == 4'd0) r = {29'd0, m_ie, m_oneshot, m_run};
        else if (a == 4'd1) r = 32'(m_period);
        else if (a == 4'd2) r = 32'(m_step) | (32'(m_busy) << 8) | (32'(m_done) << 9);
        else if (int'(a) >= 8 && int'(a) < 8 + NUM_STEPS) r = 32'(m_tbl[int'(a) - 8]);
        return r;
    endfunction

    // Behavioural reference, updated on the same edges as the DUT.
    always @(posedge clk or negedge reset_n) begin : model
        bit wr, busy, issuing, run, done, ie;
        int gap, step;
        logic [31:0] wd;
        if (!reset_n) begin
            m_busy <= 1'b0; m_issuing <= 1'b0; m_gap <= 0; m_step <= 0;
            m_run <= 1'b0; m_oneshot <= 1'b0; m_ie <= 1'b0; m_done <= 1'b0;
            m_period <= 0; m_tbl <= '{default: '0};
            exp_cs <= 1'b0; exp_wdata <= 32'd0; exp_irq <= 1'b0;
        end else begin
            wr = s_chipselect && !s_write_n;
            busy = m_busy; issuing = m_issuing; gap = m_gap; step = m_step;
            run = m_run; done = m_done; ie = m_ie; wd = exp_wdata;
            if (!busy) begin
                if (wr && s_address == 4'd0 && s_writedata[0] && !m_run) begin
                    busy = 1'b1; issuing = 1'b1; step = 0; wd = 32'(m_tbl[0]);
                end
            end else if (issuing) begin
                if (!m_waitrequest) begin
                    issuing = 1'b0;
                    if (m_run) gap = m_period + 1;
                    else busy = 1'b0;
                end
            end else begin
                if (!m_run) busy = 1'b0;
                else if (gap == 1) begin
                    if (m_oneshot && step == NUM_STEPS - 1) busy = 1'b0;
                    else begin
                        step = (step + 1) % NUM_STEPS;
                        issuing = 1'b1;
                        wd = 32'(m_tbl[step]);
                    end
                end else gap = gap - 1;
            end
            if (wr) begin
                if (s_address == 4'd0) begin
                    run = s_writedata[0];
                    m_oneshot <= s_writedata[1];
`ifdef LED_SEQ_IRQ_EN
                    ie = s_writedata[2];
`endif
                end else if (s_address == 4'd1) m_period <= int'(s_writedata[PERIOD_W-1:0]);
                else if (s_address == 4'd2) done = 1'b0;
                else if (int'(s_address) >= 8 && int'(s_address) < 8 + NUM_STEPS)
                    m_tbl[int'(s_address) - 8] <= s_writedata[LED_W-1:0];
            end
            // One-shot completion: this is the only way busy falls from the gap phase with run still set.
            if (m_busy && !m_issuing && m_run && !busy) begin
                done = 1'b1;
                run = 1'b0;
            end
            m_busy <= busy; m_issuing <= issuing; m_gap <= gap; m_step <= step;
            m_run <= run; m_done <= done; m_ie <= ie;
            exp_cs <= issuing; exp_wdata <= wd; exp_irq <= done && ie;
        end
    end

    // Per-cycle compare of master outputs and log of accepted writes.
    always @(negedge clk) begin
        chk("m_chipselect", 32'(m_chipselect), 32'(exp_cs));
        chk("m_write_n", 32'(m_write_n), 32'(!exp_cs));
        chk("m_address", 32'(m_address), 32'd0);
        if (exp_cs) chk("m_writedata", m_writedata, exp_wdata);
`ifdef LED_SEQ_IRQ_EN
        chk("irq", 32'(irq), 32'(exp_irq));
`endif
        if (reset_n && m_chipselect && !m_waitrequest) begin
            acc_cyc.push_back(cyc);
            acc_dat.push_back(m_writedata);
        end
    end

    task automatic idle_bus();
        s_chipselect = 1'b0; s_write_n = 1'b1; s_address = 4'd0; s_writedata = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_rand_en) m_waitrequest = ($urandom_range(0, 99) < 30);
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
        s_chipselect = 1'b1; s_write_n = 1'b0; s_address = a; s_writedata = d;
        tick();
        idle_bus();
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        s_chipselect = 1'b1; s_write_n = 1'b1; s_address = a;
        #1;
        d = s_readdata;
        idle_bus();
    endtask

    task automatic wait_idle(input string name, input int min_writes, input int limit);
        int n;
        n = 0;
        while ((m_busy || acc_cyc.size() < min_writes) && n < limit) begin
            tick();
            n++;
        end
        chk(name, 32'(n < limit), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] seq_exp [5];
        int n, base;
        seq_exp = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        reset_n = 1'b0;
        m_waitrequest = 1'b0;
        idle_bus();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 32'(m_chipselect), 32'd0);
        chk("rst_write_n", 32'(m_write_n), 32'd1);
        chk("rst_wdata", m_writedata, 32'd0);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            chk("rst_read", d, 32'd0);
        end
        reset_n = 1'b1;
        tick();

        // Continuous run, zero-wait fabric
        reg_wr(4'd8, 32'd1); reg_wr(4'd9, 32'd2); reg_wr(4'd10, 32'd3); reg_wr(4'd11, 32'd0);
        reg_wr(4'd1, 32'd3);
        rd(4'd9, d); chk("step1_rb", d, 32'd2);
        rd(4'd1, d); chk("period_rb", d, 32'd3);
        reg_wr(4'd0, 32'd1);
        n = 0;
        while (acc_cyc.size() < 5 && n < 100) begin
            rd(4'd2, d);
            chk("t2_busy", 32'(d[8]), 32'd1);
            tick();
            n++;
        end
        chk("t2_timeout", 32'(acc_cyc.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < acc_cyc.size(); i++) begin
            chk("t2_data", acc_dat[i], seq_exp[i]);
            if (i > 0) chk("t2_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd5);
        end

        // Waitrequest stall on step 1
        m_waitrequest = 1'b1;
        n = 0;
        while (!m_chipselect && n < 50) begin tick(); n++; end
        chk("t3_timeout", 32'(n < 50), 32'd1);
        base = acc_cyc.size();
        for (int i = 0; i < 4; i++) begin
            chk("t3_stall_cs", 32'(m_chipselect), 32'd1);
            chk("t3_stall_wn", 32'(m_write_n), 32'd0);
            chk("t3_stall_data", m_writedata, 32'd2);
            tick();
        end
        m_waitrequest = 1'b0;
        n = 0;
        while (acc_cyc.size() < base + 2 && n < 50) begin tick(); n++; end
        chk("t3_timeout2", 32'(acc_cyc.size() >= base + 2), 32'd1);
        if (acc_cyc.size() >= base + 2) begin
            chk("t3_data0", acc_dat[base], 32'd2);
            chk("t3_data1", acc_dat[base+1], 32'd3);
            chk("t3_spacing", 32'(acc_cyc[base+1] - acc_cyc[base]), 32'd5);
        end

        // Stop while a transfer is stalled
        m_waitrequest = 1'b1;
        n = 0;
        while (!m_chipselect && n < 50) begin tick(); n++; end
        chk("t4_timeout", 32'(n < 50), 32'd1);
        reg_wr(4'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t4_held_cs", 32'(m_chipselect), 32'd1);
            tick();
        end
        m_waitrequest = 1'b0;
        tick();
        tick();
        rd(4'd2, d);
        chk("t4_busy", 32'(d[8]), 32'd0);
        base = acc_cyc.size();
        repeat (20) tick();
        chk("t4_no_writes", 32'(acc_cyc.size()), 32'(base));

        // One-shot, PERIOD=0
        acc_cyc.delete(); acc_dat.delete();
        reg_wr(4'd1, 32'd0);
        reg_wr(4'd0, 32'd3);
        wait_idle("t5_timeout", 4, 80);
        repeat (10) tick();
        chk("t5_count", 32'(acc_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_cyc.size(); i++) begin
            chk("t5_data", acc_dat[i], seq_exp[i]);
            if (i > 0) chk("t5_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
        end
        rd(4'd2, d); chk("t5_status_done", d, 32'h0000_0203);
        rd(4'd0, d); chk("t5_ctrl", d, 32'h0000_0002);
        reg_wr(4'd2, 32'd0);
        rd(4'd2, d); chk("t5_status_clr", d, 32'h0000_0003);

        // One-shot with ie
        acc_cyc.delete(); acc_dat.delete();
        reg_wr(4'd0, 32'd7);
        rd(4'd0, d);
`ifdef LED_SEQ_IRQ_EN
        chk("t6_ctrl", d, 32'h0000_0007);
`else
        chk("t6_ctrl", d, 32'h0000_0003);
`endif
        wait_idle("t6_timeout", 4, 80);
`ifdef LED_SEQ_IRQ_EN
        chk("t6_irq_set", 32'(irq), 32'd1);
        reg_wr(4'd2, 32'd0);
        chk("t6_irq_clr", 32'(irq), 32'd0);
`else
        reg_wr(4'd2, 32'd0);
`endif
        rd(4'd2, d); chk("t6_status_clr", d, 32'h0000_0003);

        // Asynchronous reset in the middle of a stalled transfer
        m_waitrequest = 1'b1;
        reg_wr(4'd0, 32'd1);
        chk("t7_cs_before", 32'(m_chipselect), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t7_cs_async", 32'(m_chipselect), 32'd0);
        chk("t7_wn_async", 32'(m_write_n), 32'd1);
        chk("t7_wdata_async", m_writedata, 32'd0);
        tick();
        rd(4'd0, d); chk("t7_ctrl", d, 32'd0);
        rd(4'd8, d); chk("t7_step0", d, 32'd0);
        m_waitrequest = 1'b0;
        reset_n = 1'b1;
        tick();

        // Randomised runs against the model
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NUM_STEPS; i++) reg_wr(4'(8 + i), $urandom);
            reg_wr(4'd1, 32'($urandom_range(0, 5)));
            wr_rand_en = 1'b1;
            reg_wr(4'd0, {30'd0, 1'($urandom_range(0, 1)), 1'b1});
            n = $urandom_range(20, 80);
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    reg_wr(4'($urandom_range(1, 15)), $urandom);
                end else begin
                    base = $urandom_range(0, 15);
                    rd(4'(base), d);
                    chk("rnd_read", d, model_read(4'(base)));
                    tick();
                end
            end
            reg_wr(4'd0, 32'd0);
            wait_idle("rnd_timeout", 0, 300);
            rd(4'd2, d);
            chk("rnd_status", d, model_read(4'd2));
            wr_rand_en = 1'b0;
            m_waitrequest = 1'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
